// File: rtl/trap_pkg.sv
// Shared constants for the machine-mode trap controller: CSR addresses,
// cause codes, mstatus field positions, CSR access modes and FSM states.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  localparam logic [4:0] CAUSE_ILLEGAL     = 5'd2;
  localparam logic [4:0] CAUSE_LOAD_FAULT  = 5'd5;
  localparam logic [4:0] CAUSE_STORE_FAULT = 5'd7;
  localparam logic [4:0] CAUSE_ECALL_M     = 5'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [1:0] WSC_READ  = 2'b00;
  localparam logic [1:0] WSC_WRITE = 2'b01;
  localparam logic [1:0] WSC_SET   = 2'b10;
  localparam logic [1:0] WSC_CLEAR = 2'b11;

  // Trap-entry sequencer states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MEPC   = 2'd1;
  localparam logic [1:0] ST_MCAUSE = 2'd2;

endpackage

// File: rtl/trap_ctrl_unit_if.sv
// Core-side bus of the trap controller: CSR access port, trap sources,
// and redirect / flush / stall controls back to the pipeline.
interface trap_ctrl_unit_if #(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 4
);
  logic               csr_rw_in;
  logic [1:0]         csr_wsc_mode_in;
  logic               csr_w_imm_mux;
  logic [11:0]        csr_rw_addr_in;
  logic [XLEN-1:0]    csr_w_data_reg;
  logic [4:0]         csr_w_data_imm;
  logic [XLEN-1:0]    csr_r_data_out;
  logic [NUM_IRQ-1:0] irq;
  logic               illegal_inst;
  logic               l_access_fault;
  logic               s_access_fault;
  logic               ecall_m;
  logic               mret;
  logic [XLEN-1:0]    epc_cur;
  logic [XLEN-1:0]    epc_next;
  logic [XLEN-1:0]    bad_addr;
  logic [XLEN-1:0]    bad_inst;
  logic [XLEN-1:0]    PC_redirect;
  logic               redirect_mux;
  logic               reg_FD_flush;
  logic               reg_DE_flush;
  logic               reg_EM_flush;
  logic               reg_MW_flush;
  logic               RegWrite_cancel;
  logic               trap_busy;

  modport master (
    output csr_rw_in, csr_wsc_mode_in, csr_w_imm_mux, csr_rw_addr_in,
           csr_w_data_reg, csr_w_data_imm, irq, illegal_inst, l_access_fault,
           s_access_fault, ecall_m, mret, epc_cur, epc_next, bad_addr, bad_inst,
    input  csr_r_data_out, PC_redirect, redirect_mux, reg_FD_flush, reg_DE_flush,
           reg_EM_flush, reg_MW_flush, RegWrite_cancel, trap_busy
  );

  modport slave (
    input  csr_rw_in, csr_wsc_mode_in, csr_w_imm_mux, csr_rw_addr_in,
           csr_w_data_reg, csr_w_data_imm, irq, illegal_inst, l_access_fault,
           s_access_fault, ecall_m, mret, epc_cur, epc_next, bad_addr, bad_inst,
    output csr_r_data_out, PC_redirect, redirect_mux, reg_FD_flush, reg_DE_flush,
           reg_EM_flush, reg_MW_flush, RegWrite_cancel, trap_busy
  );
endinterface

// File: rtl/trap_csr_file.sv
// M-mode CSR storage: read mux, write/set/clear merge, field masking, and
// the hardware updates made on trap entry, mret and the trap sequence.
module trap_csr_file
  import trap_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_IRQ  = 4,
  parameter int IRQ_BASE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_en_i,
  input  logic [1:0]         csr_mode_i,
  input  logic [11:0]        csr_addr_i,
  input  logic [XLEN-1:0]    csr_op_i,
  output logic [XLEN-1:0]    csr_rdata_o,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               trap_enter_i,
  input  logic               mret_i,
  input  logic               mepc_we_i,
  input  logic [XLEN-1:0]    mepc_wdata_i,
  input  logic               cause_we_i,
  input  logic [XLEN-1:0]    mcause_wdata_i,
  input  logic [XLEN-1:0]    mtval_wdata_i,
  output logic               mstatus_mie_o,
  output logic [NUM_IRQ-1:0] mie_irq_o,
  output logic [XLEN-1:0]    mtvec_o,
  output logic [XLEN-1:0]    mepc_o
);

  // Only MIE, MPIE and MPP exist in mstatus; mie holds only the local lines
  localparam logic [XLEN-1:0] MSTATUS_MASK = (XLEN'(1) << MSTATUS_MIE) |
                                             (XLEN'(1) << MSTATUS_MPIE) |
                                             (XLEN'(3) << MSTATUS_MPP_LO);
  localparam logic [XLEN-1:0] MIE_MASK   = XLEN'((64'd1 << NUM_IRQ) - 64'd1) << IRQ_BASE;
  localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(2);
  localparam logic [XLEN-1:0] MEPC_MASK  = ~XLEN'(3);

  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] merged;
  logic            do_write;

  // Read mux; unimplemented addresses read zero
  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      CSR_MSTATUS:  csr_rdata_o = mstatus_q;
      CSR_MIE:      csr_rdata_o = mie_q;
      CSR_MTVEC:    csr_rdata_o = mtvec_q;
      CSR_MSCRATCH: csr_rdata_o = mscratch_q;
      CSR_MEPC:     csr_rdata_o = mepc_q;
      CSR_MCAUSE:   csr_rdata_o = mcause_q;
      CSR_MTVAL:    csr_rdata_o = mtval_q;
      CSR_MIP:      csr_rdata_o = XLEN'(irq_i) << IRQ_BASE;
      default:      csr_rdata_o = '0;
    endcase
  end

  // Merge the operand with the old value according to the access mode
  always_comb begin
    merged = csr_rdata_o;
    case (csr_mode_i)
      WSC_WRITE: merged = csr_op_i;
      WSC_SET:   merged = csr_rdata_o | csr_op_i;
      WSC_CLEAR: merged = csr_rdata_o & ~csr_op_i;
      default:   merged = csr_rdata_o;
    endcase
  end

  // Set/clear with a zero operand is a pure read
  assign do_write = csr_en_i & ((csr_mode_i == WSC_WRITE) |
                                ((csr_mode_i != WSC_READ) & (csr_op_i != '0)));

  // Next-state of every CSR; the controller never asserts two writers at once
  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (do_write) begin
      case (csr_addr_i)
        CSR_MSTATUS:  mstatus_d  = merged & MSTATUS_MASK;
        CSR_MIE:      mie_d      = merged & MIE_MASK;
        CSR_MTVEC:    mtvec_d    = merged & MTVEC_MASK;
        CSR_MSCRATCH: mscratch_d = merged;
        CSR_MEPC:     mepc_d     = merged & MEPC_MASK;
        CSR_MCAUSE:   mcause_d   = merged;
        CSR_MTVAL:    mtval_d    = merged;
        default:      ;
      endcase
    end
    if (trap_enter_i) begin
      mstatus_d[MSTATUS_MPIE]                  = mstatus_q[MSTATUS_MIE];
      mstatus_d[MSTATUS_MIE]                   = 1'b0;
      mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end
    if (mret_i) begin
      mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
      mstatus_d[MSTATUS_MPIE] = 1'b1;
    end
    if (mepc_we_i) mepc_d = mepc_wdata_i & MEPC_MASK;
    if (cause_we_i) begin
      mcause_d = mcause_wdata_i;
      mtval_d  = mtval_wdata_i;
    end
  end

  // CSR registers, cleared by the asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  assign mstatus_mie_o = mstatus_q[MSTATUS_MIE];
  assign mie_irq_o     = mie_q[IRQ_BASE +: NUM_IRQ];
  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;

endmodule

// File: rtl/trap_ctrl_unit.sv
// Machine-mode trap controller beside the MEM stage: trap arbitration,
// trap-entry sequencing, mret handling, redirect and pipeline flush/stall.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | normal flow; arbitrate traps, serve mret and CSR accesses
//   ST_MEPC   | trap accepted last cycle; mepc <= latched EPC
//   ST_MCAUSE | mcause/mtval <= latched CAUSE/TVAL; redirect to the handler
module trap_ctrl_unit
  import trap_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_IRQ  = 4,
  parameter int IRQ_BASE = 16,
  parameter bit VEC_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  trap_ctrl_unit_if.slave  bus
);

  logic [1:0]         state_q, state_d;
  logic [XLEN-1:0]    epc_q, epc_d;
  logic [XLEN-1:0]    cause_q, cause_d;
  logic [XLEN-1:0]    tval_q, tval_d;
  logic               idle, exc, int_take, trap, mret_take, csr_take;
  logic [4:0]         exc_code;
  logic [XLEN-2:0]    int_code;
  logic [NUM_IRQ-1:0] irq_pend;
  logic [XLEN-1:0]    csr_op, csr_rdata, mtvec, mepc, trap_target;
  logic               mstatus_mie;
  logic [NUM_IRQ-1:0] mie_irq;

  assign idle      = (state_q == ST_IDLE);
  assign exc       = bus.illegal_inst | bus.l_access_fault | bus.s_access_fault | bus.ecall_m;
  assign irq_pend  = bus.irq & mie_irq;
  assign int_take  = mstatus_mie & (|irq_pend) & ~exc;
  assign trap      = idle & (exc | int_take);
  assign mret_take = idle & bus.mret & ~(exc | int_take);
  assign csr_take  = idle & bus.csr_rw_in & ~bus.mret & ~(exc | int_take);
  assign csr_op    = bus.csr_w_imm_mux ? XLEN'(bus.csr_w_data_imm) : bus.csr_w_data_reg;

  // Fixed exception priority: illegal > load fault > store fault > ecall
  always_comb begin
    exc_code = CAUSE_ECALL_M;
    if (bus.illegal_inst)        exc_code = CAUSE_ILLEGAL;
    else if (bus.l_access_fault) exc_code = CAUSE_LOAD_FAULT;
    else if (bus.s_access_fault) exc_code = CAUSE_STORE_FAULT;
  end

  // Lowest-index pending line wins; scanning downward lets it overwrite last
  always_comb begin
    int_code = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_pend[i]) int_code = (XLEN-1)'(IRQ_BASE + i);
    end
  end

  // Trap record captured at acceptance, written out over the next two cycles
  always_comb begin
    epc_d   = epc_q;
    cause_d = cause_q;
    tval_d  = tval_q;
    if (trap) begin
      epc_d   = exc ? bus.epc_cur : bus.epc_next;
      cause_d = exc ? {1'b0, (XLEN-1)'(exc_code)} : {1'b1, int_code};
      if (bus.illegal_inst)                              tval_d = bus.bad_inst;
      else if (bus.l_access_fault | bus.s_access_fault) tval_d = bus.bad_addr;
      else                                               tval_d = '0;
    end
  end

  // Sequencer next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (trap) state_d = ST_MEPC;
      ST_MEPC:   state_d = ST_MCAUSE;
      ST_MCAUSE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and trap record registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      epc_q   <= '0;
      cause_q <= '0;
      tval_q  <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      tval_q  <= tval_d;
    end
  end

  trap_csr_file #(
    .XLEN     (XLEN),
    .NUM_IRQ  (NUM_IRQ),
    .IRQ_BASE (IRQ_BASE)
  ) u_csr (
    .clk            (clk),
    .rst            (rst),
    .csr_en_i       (csr_take),
    .csr_mode_i     (bus.csr_wsc_mode_in),
    .csr_addr_i     (bus.csr_rw_addr_in),
    .csr_op_i       (csr_op),
    .csr_rdata_o    (csr_rdata),
    .irq_i          (bus.irq),
    .trap_enter_i   (trap),
    .mret_i         (mret_take),
    .mepc_we_i      (state_q == ST_MEPC),
    .mepc_wdata_i   (epc_q),
    .cause_we_i     (state_q == ST_MCAUSE),
    .mcause_wdata_i (cause_q),
    .mtval_wdata_i  (tval_q),
    .mstatus_mie_o  (mstatus_mie),
    .mie_irq_o      (mie_irq),
    .mtvec_o        (mtvec),
    .mepc_o         (mepc)
  );

  // Handler address: vectored only for interrupts (cause MSB shifts out)
  always_comb begin
    trap_target = mtvec & ~XLEN'(3);
    if (VEC_EN && mtvec[0] && cause_q[XLEN-1]) trap_target = trap_target + (cause_q << 2);
  end

  // Pipeline controls; everything is held low while in reset
  always_comb begin
    bus.csr_r_data_out  = '0;
    bus.PC_redirect     = '0;
    bus.redirect_mux    = 1'b0;
    bus.reg_FD_flush    = 1'b0;
    bus.reg_DE_flush    = 1'b0;
    bus.reg_EM_flush    = 1'b0;
    bus.reg_MW_flush    = 1'b0;
    bus.RegWrite_cancel = 1'b0;
    bus.trap_busy       = 1'b0;
    if (!rst) begin
      bus.csr_r_data_out = csr_rdata;
      case (state_q)
        ST_IDLE: begin
          if (trap) begin
            bus.reg_FD_flush    = 1'b1;
            bus.reg_DE_flush    = 1'b1;
            bus.reg_EM_flush    = 1'b1;
            bus.reg_MW_flush    = 1'b1;
            bus.RegWrite_cancel = exc;
          end else if (mret_take) begin
            bus.redirect_mux = 1'b1;
            bus.PC_redirect  = mepc;
            bus.reg_FD_flush = 1'b1;
            bus.reg_DE_flush = 1'b1;
            bus.reg_EM_flush = 1'b1;
          end
        end
        ST_MEPC: begin
          bus.reg_FD_flush = 1'b1;
          bus.trap_busy    = 1'b1;
        end
        ST_MCAUSE: begin
          bus.redirect_mux = 1'b1;
          bus.PC_redirect  = trap_target;
          bus.reg_FD_flush = 1'b1;
          bus.trap_busy    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl_unit.sv
// Bench for trap_ctrl_unit: scenario tasks with a queue scoreboard of
// expected CSR read values and redirect targets.
module tb_trap_ctrl_unit;
  import trap_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] sb_q[$];

  typedef struct packed {
    logic [1:0]  mode;
    logic [11:0] addr;
    logic        imm_sel;
    logic [31:0] wreg;
    logic [4:0]  imm;
    logic [31:0] exp;
  } csr_vec_t;

  trap_ctrl_unit_if #(.XLEN(32), .NUM_IRQ(4)) bus ();

  trap_ctrl_unit #(.XLEN(32), .NUM_IRQ(4), .IRQ_BASE(16), .VEC_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.csr_rw_in = 0; bus.csr_wsc_mode_in = 0; bus.csr_w_imm_mux = 0;
    bus.csr_rw_addr_in = 0; bus.csr_w_data_reg = 0; bus.csr_w_data_imm = 0;
    bus.irq = 0; bus.illegal_inst = 0; bus.l_access_fault = 0;
    bus.s_access_fault = 0; bus.ecall_m = 0; bus.mret = 0;
    bus.epc_cur = 0; bus.epc_next = 0; bus.bad_addr = 0; bus.bad_inst = 0;
  endtask

  // One CSR instruction in MEM; returns rd, write lands at the next edge
  task automatic csr_access(input logic [1:0] mode, input logic [11:0] addr,
                            input logic imm_sel, input logic [31:0] wreg,
                            input logic [4:0] imm, output logic [31:0] rd);
    bus.csr_rw_in = 1; bus.csr_wsc_mode_in = mode; bus.csr_rw_addr_in = addr;
    bus.csr_w_imm_mux = imm_sel; bus.csr_w_data_reg = wreg; bus.csr_w_data_imm = imm;
    #2;
    rd = bus.csr_r_data_out;
    @(posedge clk); #1;
    bus.csr_rw_in = 0; bus.csr_wsc_mode_in = 0; bus.csr_rw_addr_in = 0;
    bus.csr_w_imm_mux = 0; bus.csr_w_data_reg = 0; bus.csr_w_data_imm = 0;
  endtask

  // Bounded search for the next redirect; cyc = whole cycles waited
  task automatic wait_redirect(output bit found, output logic [31:0] pc, output int cyc);
    found = 0; pc = 0; cyc = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      #1;
      if (bus.redirect_mux) begin
        found = 1; pc = bus.PC_redirect; cyc = i;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd, e;
    logic [11:0] addrs [9];
    clear_inputs();
    rst = 1;
    bus.irq = 4'hF; bus.illegal_inst = 1; bus.csr_rw_in = 1; bus.csr_rw_addr_in = CSR_MIP;
    #12;
    total++;
    if ({bus.redirect_mux, bus.reg_FD_flush, bus.reg_DE_flush, bus.reg_EM_flush,
         bus.reg_MW_flush, bus.RegWrite_cancel, bus.trap_busy} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0", {bus.redirect_mux, bus.reg_FD_flush,
        bus.reg_DE_flush, bus.reg_EM_flush, bus.reg_MW_flush, bus.RegWrite_cancel, bus.trap_busy});
    end
    total++;
    if (bus.csr_r_data_out !== 32'h0) begin
      bad++; $display("FAIL reset_rdata got=%h exp=0", bus.csr_r_data_out);
    end
    clear_inputs();
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    addrs = '{CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
              CSR_MCAUSE, CSR_MTVAL, CSR_MIP, 12'h7C0};
    for (int i = 0; i < 9; i++) sb_q.push_back(32'h0);
    for (int i = 0; i < 9; i++) begin
      csr_access(WSC_READ, addrs[i], 1'b0, 32'h0, 5'd0, rd);
      e = sb_q.pop_front(); total++;
      if (rd !== e) begin bad++; $display("FAIL reset_csr[%h] got=%h exp=%h", addrs[i], rd, e); end
    end
  endtask

  task automatic test_csr_access();
    logic [31:0] rd, e;
    csr_vec_t v [14];
    v = '{
      '{WSC_WRITE, CSR_MTVEC,    1'b0, 32'h100,       5'd0, 32'h0},
      '{WSC_SET,   CSR_MSTATUS,  1'b0, 32'h8,         5'd0, 32'h0},
      '{WSC_READ,  CSR_MSTATUS,  1'b0, 32'h0,         5'd0, 32'h8},
      '{WSC_WRITE, 12'h7C0,      1'b0, 32'h1234,      5'd0, 32'h0},
      '{WSC_READ,  12'h7C0,      1'b0, 32'h0,         5'd0, 32'h0},
      '{WSC_WRITE, CSR_MSCRATCH, 1'b0, 32'hA5A5A5A5,  5'd0, 32'h0},
      '{WSC_SET,   CSR_MSCRATCH, 1'b1, 32'h0,         5'd3, 32'hA5A5A5A5},
      '{WSC_CLEAR, CSR_MSCRATCH, 1'b0, 32'h5,         5'd0, 32'hA5A5A5A7},
      '{WSC_SET,   CSR_MSCRATCH, 1'b0, 32'h0,         5'd0, 32'hA5A5A5A2},
      '{WSC_CLEAR, CSR_MSCRATCH, 1'b1, 32'hFFFFFFFF,  5'd0, 32'hA5A5A5A2},
      '{WSC_READ,  CSR_MSCRATCH, 1'b0, 32'h0,         5'd0, 32'hA5A5A5A2},
      '{WSC_WRITE, CSR_MEPC,     1'b0, 32'h123,       5'd0, 32'h0},
      '{WSC_READ,  CSR_MEPC,     1'b0, 32'h0,         5'd0, 32'h120},
      '{WSC_READ,  CSR_MTVEC,    1'b0, 32'h0,         5'd0, 32'h100}
    };
    for (int i = 0; i < 14; i++) begin
      sb_q.push_back(v[i].exp);
      csr_access(v[i].mode, v[i].addr, v[i].imm_sel, v[i].wreg, v[i].imm, rd);
      e = sb_q.pop_front(); total++;
      if (rd !== e) begin bad++; $display("FAIL csr_step%0d got=%h exp=%h", i, rd, e); end
    end
  endtask

  task automatic test_exception();
    logic [31:0] rd, e, pc;
    bit found;
    int cyc;
    logic [11:0] addrs [4];
    logic [31:0] exps [4];
    bus.illegal_inst = 1; bus.bad_inst = 32'hFFFFFFFF; bus.epc_cur = 32'h40;
    bus.epc_next = 32'h44; bus.bad_addr = 32'h999;
    #1;
    total++;
    if ({bus.RegWrite_cancel, bus.reg_FD_flush, bus.reg_DE_flush, bus.reg_EM_flush,
         bus.reg_MW_flush, bus.redirect_mux} !== 6'b111110) begin
      bad++; $display("FAIL exc_T got=%b exp=111110", {bus.RegWrite_cancel, bus.reg_FD_flush,
        bus.reg_DE_flush, bus.reg_EM_flush, bus.reg_MW_flush, bus.redirect_mux});
    end
    sb_q.push_back(32'h100);
    @(posedge clk); #1;
    clear_inputs();
    bus.ecall_m = 1;  // must be ignored while the sequence runs
    #1;
    total++;
    if ({bus.trap_busy, bus.reg_FD_flush, bus.reg_DE_flush, bus.RegWrite_cancel, bus.redirect_mux} !== 5'b11000) begin
      bad++; $display("FAIL exc_T1 got=%b exp=11000", {bus.trap_busy, bus.reg_FD_flush,
        bus.reg_DE_flush, bus.RegWrite_cancel, bus.redirect_mux});
    end
    wait_redirect(found, pc, cyc);
    e = sb_q.pop_front(); total++;
    if (!found || pc !== e || cyc != 1 || bus.trap_busy !== 1'b1) begin
      bad++; $display("FAIL exc_redirect found=%0d cyc=%0d got=%h exp=%h at T+2", found, cyc, pc, e);
    end
    bus.ecall_m = 0;
    @(posedge clk); #1;
    addrs = '{CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MSTATUS};
    exps  = '{32'h40, 32'h2, 32'hFFFFFFFF, 32'h1880};
    for (int i = 0; i < 4; i++) sb_q.push_back(exps[i]);
    for (int i = 0; i < 4; i++) begin
      csr_access(WSC_READ, addrs[i], 1'b0, 32'h0, 5'd0, rd);
      e = sb_q.pop_front(); total++;
      if (rd !== e) begin bad++; $display("FAIL exc_csr[%h] got=%h exp=%h", addrs[i], rd, e); end
    end
  endtask

  task automatic test_interrupt();
    logic [31:0] rd, e, pc;
    bit found;
    int cyc;
    logic [11:0] addrs [4];
    logic [31:0] exps [4];
    csr_access(WSC_WRITE, CSR_MIE, 1'b0, 32'hFFFFFFFF, 5'd0, rd);
    sb_q.push_back(32'h000F0000);
    csr_access(WSC_READ, CSR_MIE, 1'b0, 32'h0, 5'd0, rd);
    e = sb_q.pop_front(); total++;
    if (rd !== e) begin bad++; $display("FAIL mie_mask got=%h exp=%h", rd, e); end
    csr_access(WSC_WRITE, CSR_MIE, 1'b0, 32'h00060000, 5'd0, rd);
    csr_access(WSC_WRITE, CSR_MTVEC, 1'b0, 32'h103, 5'd0, rd);
    sb_q.push_back(32'h101);
    csr_access(WSC_READ, CSR_MTVEC, 1'b0, 32'h0, 5'd0, rd);
    e = sb_q.pop_front(); total++;
    if (rd !== e) begin bad++; $display("FAIL mtvec_mask got=%h exp=%h", rd, e); end
    csr_access(WSC_SET, CSR_MSTATUS, 1'b1, 32'h0, 5'd8, rd);
    bus.irq = 4'b0110; bus.epc_next = 32'h88; bus.epc_cur = 32'h84;
    #1;
    total++;
    if ({bus.RegWrite_cancel, bus.reg_FD_flush, bus.reg_DE_flush, bus.reg_EM_flush,
         bus.reg_MW_flush} !== 5'b01111) begin
      bad++; $display("FAIL irq_T got=%b exp=01111", {bus.RegWrite_cancel, bus.reg_FD_flush,
        bus.reg_DE_flush, bus.reg_EM_flush, bus.reg_MW_flush});
    end
    sb_q.push_back(32'h144);
    @(posedge clk); #1;
    clear_inputs();
    wait_redirect(found, pc, cyc);
    e = sb_q.pop_front(); total++;
    if (!found || pc !== e || cyc != 1) begin
      bad++; $display("FAIL irq_redirect found=%0d cyc=%0d got=%h exp=%h", found, cyc, pc, e);
    end
    @(posedge clk); #1;
    addrs = '{CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MSTATUS};
    exps  = '{32'h88, 32'h80000011, 32'h0, 32'h1880};
    for (int i = 0; i < 4; i++) sb_q.push_back(exps[i]);
    for (int i = 0; i < 4; i++) begin
      csr_access(WSC_READ, addrs[i], 1'b0, 32'h0, 5'd0, rd);
      e = sb_q.pop_front(); total++;
      if (rd !== e) begin bad++; $display("FAIL irq_csr[%h] got=%h exp=%h", addrs[i], rd, e); end
    end
  endtask

  task automatic test_priority_mret();
    logic [31:0] rd, e, pc;
    bit found;
    int cyc;
    logic [11:0] addrs [4];
    logic [31:0] exps [4];
    csr_access(WSC_SET, CSR_MSTATUS, 1'b0, 32'h8, 5'd0, rd);
    csr_access(WSC_SET, CSR_MIE, 1'b0, 32'h00010000, 5'd0, rd);
    bus.ecall_m = 1; bus.irq = 4'b0001; bus.mret = 1;
    bus.csr_rw_in = 1; bus.csr_wsc_mode_in = WSC_WRITE; bus.csr_rw_addr_in = CSR_MSCRATCH;
    bus.csr_w_data_reg = 32'hDEAD; bus.epc_cur = 32'h200; bus.epc_next = 32'h204;
    #1;
    total++;
    if ({bus.RegWrite_cancel, bus.redirect_mux, bus.reg_MW_flush} !== 3'b101) begin
      bad++; $display("FAIL prio_T got=%b exp=101", {bus.RegWrite_cancel, bus.redirect_mux, bus.reg_MW_flush});
    end
    sb_q.push_back(32'h100);
    @(posedge clk); #1;
    clear_inputs();
    wait_redirect(found, pc, cyc);
    e = sb_q.pop_front(); total++;
    if (!found || pc !== e || cyc != 1) begin
      bad++; $display("FAIL prio_redirect found=%0d cyc=%0d got=%h exp=%h", found, cyc, pc, e);
    end
    @(posedge clk); #1;
    addrs = '{CSR_MCAUSE, CSR_MEPC, CSR_MSCRATCH, CSR_MSTATUS};
    exps  = '{32'd11, 32'h200, 32'hA5A5A5A2, 32'h1880};
    for (int i = 0; i < 4; i++) sb_q.push_back(exps[i]);
    for (int i = 0; i < 4; i++) begin
      csr_access(WSC_READ, addrs[i], 1'b0, 32'h0, 5'd0, rd);
      e = sb_q.pop_front(); total++;
      if (rd !== e) begin bad++; $display("FAIL prio_csr[%h] got=%h exp=%h", addrs[i], rd, e); end
    end
    sb_q.push_back(32'h200);
    bus.mret = 1;
    #1;
    e = sb_q.pop_front(); total++;
    if (bus.redirect_mux !== 1'b1 || bus.PC_redirect !== e) begin
      bad++; $display("FAIL mret_redirect got=%b/%h exp=1/%h", bus.redirect_mux, bus.PC_redirect, e);
    end
    total++;
    if ({bus.reg_FD_flush, bus.reg_DE_flush, bus.reg_EM_flush, bus.reg_MW_flush,
         bus.RegWrite_cancel, bus.trap_busy} !== 6'b111000) begin
      bad++; $display("FAIL mret_flush got=%b exp=111000", {bus.reg_FD_flush, bus.reg_DE_flush,
        bus.reg_EM_flush, bus.reg_MW_flush, bus.RegWrite_cancel, bus.trap_busy});
    end
    @(posedge clk); #1;
    bus.mret = 0;
    sb_q.push_back(32'h1888);
    csr_access(WSC_READ, CSR_MSTATUS, 1'b0, 32'h0, 5'd0, rd);
    e = sb_q.pop_front(); total++;
    if (rd !== e) begin bad++; $display("FAIL mret_mstatus got=%h exp=%h", rd, e); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, e, pc;
    bit found;
    int cyc;
    logic [11:0] addrs [4];
    bus.illegal_inst = 1; bus.epc_cur = 32'h300; bus.bad_inst = 32'h1;
    @(posedge clk); #1;
    clear_inputs();
    rst = 1;
    #1;
    total++;
    if ({bus.redirect_mux, bus.trap_busy, bus.reg_FD_flush} !== 3'b000) begin
      bad++; $display("FAIL midrst_out got=%b exp=000", {bus.redirect_mux, bus.trap_busy, bus.reg_FD_flush});
    end
    @(posedge clk); #1;
    rst = 0;
    wait_redirect(found, pc, cyc);
    total++;
    if (found) begin bad++; $display("FAIL midrst_redirect got=%h after %0d cycles exp=none", pc, cyc); end
    addrs = '{CSR_MEPC, CSR_MCAUSE, CSR_MSTATUS, CSR_MTVEC};
    for (int i = 0; i < 4; i++) sb_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      csr_access(WSC_READ, addrs[i], 1'b0, 32'h0, 5'd0, rd);
      e = sb_q.pop_front(); total++;
      if (rd !== e) begin bad++; $display("FAIL midrst_csr[%h] got=%h exp=%h", addrs[i], rd, e); end
    end
  endtask

  initial begin
    test_reset();
    test_csr_access();
    test_exception();
    test_interrupt();
    test_priority_mret();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
